// File: rtl/led_panel_scan.sv
// led_panel_scan: multiplexed RGB LED panel scanner with a double-buffered
// 3-bit-per-pixel frame store. The host writes the back bank, and the banks
// are exchanged only at a frame boundary.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// SETUP    | start a row: clear aclk/arst pulses, keep blanked, col=0
// SHIFT_LO | drive pixel {row,col} and drop sclk
// SHIFT_HI | raise sclk (data valid at this edge), advance col
// LATCH    | pulse latch to transfer the shifted row, clear rgb
// UNBLANK  | end the latch pulse, turn LEDs on, start the dwell count
// DWELL    | hold the row lit for dwell_in+1 cycles
// NEXTROW  | advance the row counter; at frame end reset it and maybe swap
module led_panel_scan #(
  parameter int COL_BITS = 5,
  parameter int ROW_BITS = 2,
  parameter int DWELL_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ROW_BITS+COL_BITS-1:0] wr_addr,
  input  logic [2:0]                   wr_rgb,
  input  logic                         swap_req,
  output logic                         swap_ack,
  input  logic [DWELL_W-1:0]           dwell_in,
  output logic                         red_out,
  output logic                         green_out,
  output logic                         blue_out,
  output logic                         sclk_out,
  output logic                         latch_out,
  output logic                         blank_out,
  output logic                         aclk_out,
  output logic                         arst_out
);

  localparam int ADDR_W = ROW_BITS + COL_BITS;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_UNBLANK,
    ST_DWELL,
    ST_NEXTROW
  } state_t;

  state_t              state, state_n;
  logic [ROW_BITS-1:0] row, row_n;
  logic [COL_BITS-1:0] col, col_n;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_cnt_n;
  logic [2:0]          rgb_q, rgb_n;
  logic                sclk_n, latch_n, blank_n, aclk_n, arst_n, ack_n;
  logic                front_sel, front_sel_n;
  logic                swap_pending, swap_pending_n;

  logic [2:0] mem_bank0 [DEPTH];
  logic [2:0] mem_bank1 [DEPTH];
  logic [2:0] front_rgb;

  assign {red_out, green_out, blue_out} = rgb_q;

  // Scan read of the displayed bank at the current {row, col}.
  always_comb begin
    front_rgb = front_sel ? mem_bank1[{row, col}] : mem_bank0[{row, col}];
  end

  // Host writes always target the bank that is not being displayed this cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_sel) mem_bank0[wr_addr] <= wr_rgb;
      else           mem_bank1[wr_addr] <= wr_rgb;
    end
  end

  // State, counters and registered panel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_SETUP;
      row          <= '0;
      col          <= '0;
      dwell_cnt    <= '0;
      rgb_q        <= 3'b000;
      sclk_out     <= 1'b1;
      latch_out    <= 1'b0;
      blank_out    <= 1'b1;
      aclk_out     <= 1'b0;
      arst_out     <= 1'b1;
      swap_ack     <= 1'b0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      state        <= state_n;
      row          <= row_n;
      col          <= col_n;
      dwell_cnt    <= dwell_cnt_n;
      rgb_q        <= rgb_n;
      sclk_out     <= sclk_n;
      latch_out    <= latch_n;
      blank_out    <= blank_n;
      aclk_out     <= aclk_n;
      arst_out     <= arst_n;
      swap_ack     <= ack_n;
      front_sel    <= front_sel_n;
      swap_pending <= swap_pending_n;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n        = state;
    row_n          = row;
    col_n          = col;
    dwell_cnt_n    = dwell_cnt;
    rgb_n          = rgb_q;
    sclk_n         = sclk_out;
    latch_n        = latch_out;
    blank_n        = blank_out;
    aclk_n         = aclk_out;
    arst_n         = arst_out;
    ack_n          = 1'b0;
    front_sel_n    = front_sel;
    swap_pending_n = swap_pending | swap_req;

    case (state)
      ST_SETUP: begin
        blank_n = 1'b1;
        arst_n  = 1'b0;
        aclk_n  = 1'b0;
        col_n   = '0;
        state_n = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        sclk_n  = 1'b0;
        rgb_n   = front_rgb;
        state_n = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        sclk_n = 1'b1;
        if (col == {COL_BITS{1'b1}}) begin
          state_n = ST_LATCH;
        end else begin
          col_n   = col + 1'b1;
          state_n = ST_SHIFT_LO;
        end
      end
      ST_LATCH: begin
        latch_n = 1'b1;
        rgb_n   = 3'b000;
        state_n = ST_UNBLANK;
      end
      ST_UNBLANK: begin
        latch_n     = 1'b0;
        blank_n     = 1'b0;
        dwell_cnt_n = '0;
        state_n     = ST_DWELL;
      end
      ST_DWELL: begin
        // Blank is raised as the dwell ends so the LEDs are lit for exactly
        // dwell_in+1 cycles; NEXTROW then keeps it high.
        if (dwell_cnt == dwell_in) begin
          blank_n = 1'b1;
          state_n = ST_NEXTROW;
        end else begin
          dwell_cnt_n = dwell_cnt + 1'b1;
        end
      end
      ST_NEXTROW: begin
        blank_n = 1'b1;
        if (row != {ROW_BITS{1'b1}}) begin
          row_n  = row + 1'b1;
          aclk_n = 1'b1;
        end else begin
          row_n  = '0;
          arst_n = 1'b1;
          if (swap_pending || swap_req) begin
            front_sel_n    = ~front_sel;
            swap_pending_n = 1'b0;
            ack_n          = 1'b1;
          end
        end
        state_n = ST_SETUP;
      end
      default: state_n = ST_SETUP;
    endcase
  end

endmodule
